// File: rtl/test_host_port.sv
// test_host_port
//   Memory-mapped simulation host that answers CPU stores/loads on the data
//   bus. Console bytes written by the program are buffered in a FIFO and
//   streamed to the bench. A store to TOHOST with bit0 set ends the run:
//   remaining console bytes drain, then halt rises with a pass/fail verdict
//   and exit code.
//
//   Optional feature macro: TEST_HOST_WATCHDOG_EN
//     When defined, a RUN-cycle watchdog forces a failing verdict
//     (exit_code = 31'h7FFF_FFFF) after TIMEOUT cycles without a verdict.
//
//   Ports
//     clock, reset        rising-edge clock, async active-high reset
//     wr_valid/wr_ready   store handshake, wr_addr/wr_data store payload
//     rd_valid/rd_addr    load request, always accepted
//     rd_resp_valid       load response one cycle later, with rd_data
//     con_valid/con_ready console byte stream out, con_data = FIFO head
//     halt, pass          run finished (sticky) and verdict
//     exit_code           program exit code (wr_data[31:1] of the verdict)
//     dbg_state           FSM state: 0 RUN, 1 DRAIN, 2 HALTED
//
//   Handshakes: a store transfers on any rising edge where wr_valid and
//   wr_ready are both high; wr_ready does not depend on wr_valid. A console
//   byte transfers on any rising edge where con_valid and con_ready are both
//   high; con_valid never drops without a transfer except on reset.
module test_host_port #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TIMEOUT    = 500
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rd_valid,
   input  logic [31:0] rd_addr,
   output logic        rd_resp_valid,
   output logic [31:0] rd_data,
   output logic        con_valid,
   output logic [7:0]  con_data,
   input  logic        con_ready,
   output logic        halt,
   output logic        pass,
   output logic [30:0] exit_code,
   output logic [1:0]  dbg_state
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t        state;
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [7:0]    mem [FIFO_DEPTH];
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [63:0]   cycle_cnt;
   logic          wr_in_win;
   logic          rd_in_win;
   logic          wr_is_tohost;
   logic          wr_is_console;
   logic          verdict_wr;
   logic [31:0]   rd_mux;

   // ---------------------------------------------------------------
   // Address decode (word offsets inside the 16-byte window)
   // ---------------------------------------------------------------
   assign wr_in_win     = (wr_addr[31:4] == BASE_ADDR[31:4]);
   assign rd_in_win     = (rd_addr[31:4] == BASE_ADDR[31:4]);
   assign wr_is_tohost  = wr_in_win && (wr_addr[3:2] == 2'd0);
   assign wr_is_console = wr_in_win && (wr_addr[3:2] == 2'd1);
   assign verdict_wr    = wr_valid && wr_is_tohost && wr_data[0];

   // ---------------------------------------------------------------
   // Console FIFO; the extra pointer MSB separates full from empty
   // ---------------------------------------------------------------
   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   // Only RUN ever stalls the CPU; DRAIN/HALTED swallow console bytes.
   assign wr_ready = !((state == ST_RUN) && wr_is_console && fifo_full);
   assign push     = wr_valid && wr_is_console && (state == ST_RUN) && !fifo_full;
   assign pop      = !fifo_empty && con_ready;

   assign con_valid = !fifo_empty;
   assign con_data  = mem[rptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (push) mem[wptr[AW-1:0]] <= wr_data[7:0];
   end

   // ---------------------------------------------------------------
   // Saturating 64-bit cycle counter
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                 cycle_cnt <= '0;
      else if (cycle_cnt != '1)  cycle_cnt <= cycle_cnt + 64'd1;
   end

`ifdef TEST_HOST_WATCHDOG_EN
   logic [31:0] wd_cnt;
   logic        wd_fire;

   assign wd_fire = (state == ST_RUN) && (wd_cnt == 32'(TIMEOUT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                 wd_cnt <= '0;
      else if (state == ST_RUN)  wd_cnt <= wd_cnt + 32'd1;
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   // ---------------------------------------------------------------
   // Run-control FSM; verdict registers latch on the RUN exit edge only
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         pass      <= 1'b0;
         exit_code <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (verdict_wr) begin
                  state     <= ST_DRAIN;
                  pass      <= (wr_data == 32'd1);
                  exit_code <= wr_data[31:1];
               end
`ifdef TEST_HOST_WATCHDOG_EN
               else if (wd_fire) begin
                  state     <= ST_DRAIN;
                  pass      <= 1'b0;
                  exit_code <= 31'h7FFF_FFFF;
               end
`endif
            end
            ST_DRAIN: begin
               if (fifo_empty) state <= ST_HALTED;
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end

   assign halt      = (state == ST_HALTED);
   assign dbg_state = state;

   // ---------------------------------------------------------------
   // Load path: registered, one-cycle latency, pre-edge status values
   // ---------------------------------------------------------------
   always_comb begin
      rd_mux = '0;
      if (rd_in_win) begin
         case (rd_addr[3:2])
            2'd2:    rd_mux = {29'b0, fifo_full, fifo_empty, halt};
            2'd3:    rd_mux = cycle_cnt[31:0];
            default: rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_resp_valid <= 1'b0;
         rd_data       <= '0;
      end else begin
         rd_resp_valid <= rd_valid;
         if (rd_valid) rd_data <= rd_mux;
      end
   end

   // Byte-lane bits of the addresses carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

endmodule

// File: tb/tb_test_host_port.sv
module tb_test_host_port;

   localparam logic [31:0] BASE      = 32'h0000_1000;
   localparam int          DEPTH     = 8;
   localparam logic [31:0] A_TOHOST  = BASE;
   localparam logic [31:0] A_CONSOLE = BASE + 32'h4;
   localparam logic [31:0] A_STATUS  = BASE + 32'h8;
   localparam logic [31:0] A_CYCLE   = BASE + 32'hC;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        rd_valid = 1'b0;
   logic [31:0] rd_addr = '0;
   logic        rd_resp_valid;
   logic [31:0] rd_data;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready = 1'b0;
   logic        halt;
   logic        pass;
   logic [30:0] exit_code;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int unsigned edges_since_rst = 0;
   logic [7:0] exp_q[$];

   test_host_port #(
      .BASE_ADDR (BASE),
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT   (50)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_addr      (rd_addr),
      .rd_resp_valid(rd_resp_valid),
      .rd_data      (rd_data),
      .con_valid    (con_valid),
      .con_data     (con_data),
      .con_ready    (con_ready),
      .halt         (halt),
      .pass         (pass),
      .exit_code    (exit_code),
      .dbg_state    (dbg_state)
   );

   // ------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------
   always #5 clock = ~clock;

   // Number of rising edges since reset release == expected CYCLE value.
   always @(posedge clock or posedge reset) begin
      if (reset) edges_since_rst <= 0;
      else       edges_since_rst <= edges_since_rst + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   // ------------------------------------------------------------
   // Driver tasks (all driving happens at the falling edge)
   // ------------------------------------------------------------
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_bus();
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_valid = 1'b0;
      rd_addr  = '0;
   endtask

   task automatic drive_wr(input logic [31:0] a, input logic [31:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
   endtask

   task automatic drive_rd(input logic [31:0] a);
      rd_valid = 1'b1;
      rd_addr  = a;
   endtask

   task automatic do_reset();
      idle_bus();
      con_ready = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
   endtask

   // ------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      checks++;
      if ({con_valid, halt, pass, rd_resp_valid, wr_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_flags got %b want 00001", {con_valid, halt, pass, rd_resp_valid, wr_ready});
      end
      checks++;
      if (exit_code !== 31'd0) begin
         errors++;
         $display("FAIL reset_exit_code got %0h want 0", exit_code);
      end
      checks++;
      if (rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_rd_data got %0h want 0", rd_data);
      end
   endtask

   task automatic test_tohost();
      logic [31:0] d;
      for (int it = 0; it < 5; it++) begin
         do_reset();
         d = (it == 0) ? 32'd1 : (it == 1) ? 32'd7 : ($urandom() | 32'd1);
         // bit0 clear: accepted, no effect
         drive_wr(A_TOHOST, d & ~32'd1);
         step();
         idle_bus();
         step();
         step();
         checks++;
         if (halt !== 1'b0) begin
            errors++;
            $display("FAIL tohost_bit0_zero it=%0d halt got %b want 0", it, halt);
         end
         // verdict write: halt two cycles after the write cycle
         drive_wr(A_TOHOST, d);
         step();
         idle_bus();
         checks++;
         if (halt !== 1'b0) begin
            errors++;
            $display("FAIL tohost_halt_early it=%0d got %b want 0", it, halt);
         end
         step();
         checks++;
         if ({halt, pass, exit_code} !== {1'b1, (d == 32'd1), d[31:1]}) begin
            errors++;
            $display("FAIL tohost_verdict it=%0d got h=%b p=%b e=%0h want h=1 p=%b e=%0h",
                     it, halt, pass, exit_code, (d == 32'd1), d[31:1]);
         end
         // sticky, first verdict wins, console dropped while halted
         drive_wr(A_TOHOST, 32'hFFFF_FFFF);
         step();
         drive_wr(A_CONSOLE, 32'h55);
         checks++;
         if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL halted_wr_ready it=%0d got %b want 1", it, wr_ready);
         end
         step();
         idle_bus();
         step();
         checks++;
         if ({halt, pass, exit_code, con_valid} !== {1'b1, (d == 32'd1), d[31:1], 1'b0}) begin
            errors++;
            $display("FAIL halted_sticky it=%0d got h=%b p=%b e=%0h cv=%b want h=1 p=%b e=%0h cv=0",
                     it, halt, pass, exit_code, con_valid, (d == 32'd1), d[31:1]);
         end
      end
   endtask

   task automatic test_console_hi();
      do_reset();
      con_ready = 1'b1;
      drive_wr(A_CONSOLE, 32'h48);
      exp_q.push_back(8'h48);
      step();
      checks++;
      if (con_valid !== 1'b1 || con_data !== exp_q[0]) begin
         errors++;
         $display("FAIL hi_first got v=%b d=%0h want v=1 d=%0h", con_valid, con_data, exp_q[0]);
      end
      drive_wr(A_CONSOLE, 32'h69);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(8'h69);
      checks++;
      if (con_valid !== 1'b1 || con_data !== exp_q[0]) begin
         errors++;
         $display("FAIL hi_second got v=%b d=%0h want v=1 d=%0h", con_valid, con_data, exp_q[0]);
      end
      drive_wr(A_TOHOST, 32'h0000_0007);
      step();
      void'(exp_q.pop_front());
      idle_bus();
      checks++;
      if (con_valid !== 1'b0 || halt !== 1'b0) begin
         errors++;
         $display("FAIL hi_drain got cv=%b h=%b want cv=0 h=0", con_valid, halt);
      end
      step();
      checks++;
      if ({halt, pass, exit_code} !== {1'b1, 1'b0, 31'd3}) begin
         errors++;
         $display("FAIL hi_verdict got h=%b p=%b e=%0h want h=1 p=0 e=3", halt, pass, exit_code);
      end
      con_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int drained;
      do_reset();
      con_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_wr(A_CONSOLE, 32'h41 + i);
         checks++;
         if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill_ready i=%0d got %b want 1", i, wr_ready);
         end
         step();
         exp_q.push_back(8'(8'h41 + i));
      end
      drive_wr(A_CONSOLE, 32'h49);
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_ready got %b want 0", wr_ready);
      end
      step();
      // pop and blocked push on the same edge: push must still stall
      con_ready = 1'b1;
      checks++;
      if (con_valid !== 1'b1 || con_data !== exp_q[0]) begin
         errors++;
         $display("FAIL bp_head got v=%b d=%0h want v=1 d=%0h", con_valid, con_data, exp_q[0]);
      end
      step();
      void'(exp_q.pop_front());
      con_ready = 1'b0;
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_after_pop_ready got %b want 1", wr_ready);
      end
      step();
      exp_q.push_back(8'h49);
      idle_bus();
      con_ready = 1'b1;
      drained = 0;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         checks++;
         if (con_valid !== 1'b1 || con_data !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_drain n=%0d got v=%b d=%0h want v=1 d=%0h", drained, con_valid, con_data, exp_q[0]);
         end
         step();
         void'(exp_q.pop_front());
         drained++;
      end
      checks++;
      if (drained != DEPTH || con_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain_count got n=%0d cv=%b want n=%0d cv=0", drained, con_valid, DEPTH);
      end
      con_ready = 1'b0;
   endtask

   task automatic test_random();
      logic        do_push;
      logic        do_pop;
      logic        rd_pend;
      logic [31:0] exp_status;
      logic [7:0]  b;
      int          sz;
      do_reset();
      rd_pend    = 1'b0;
      exp_status = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         sz = exp_q.size();
         b  = 8'($urandom_range(0, 255));
         wr_addr   = A_CONSOLE;
         wr_data   = {24'h0, b};
         wr_valid  = ($urandom_range(0, 99) < 60);
         con_ready = (cyc < 200) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 70);
         // check the registered response of last cycle's STATUS read
         if (rd_pend) begin
            checks++;
            if (rd_resp_valid !== 1'b1 || rd_data !== exp_status) begin
               errors++;
               $display("FAIL rnd_status cyc=%0d got v=%b d=%0h want v=1 d=%0h", cyc, rd_resp_valid, rd_data, exp_status);
            end
         end
         rd_valid = ($urandom_range(0, 99) < 25);
         rd_addr  = A_STATUS;
         rd_pend  = rd_valid;
         exp_status = {29'b0, (sz == DEPTH), (sz == 0), 1'b0};
         checks++;
         if (con_valid !== (sz != 0) || wr_ready !== (sz != DEPTH)) begin
            errors++;
            $display("FAIL rnd_flags cyc=%0d got cv=%b wr=%b want cv=%b wr=%b",
                     cyc, con_valid, wr_ready, (sz != 0), (sz != DEPTH));
         end
         if (sz != 0) begin
            checks++;
            if (con_data !== exp_q[0]) begin
               errors++;
               $display("FAIL rnd_data cyc=%0d got %0h want %0h", cyc, con_data, exp_q[0]);
            end
         end
         do_pop  = (sz != 0) && con_ready;
         do_push = wr_valid && (sz != DEPTH);
         step();
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(b);
      end
      idle_bus();
      con_ready = 1'b0;
   endtask

   task automatic test_reads();
      logic [31:0] exp_cyc;
      do_reset();
      for (int c = 0; c < 100 && edges_since_rst < 20; c++) step();
      checks++;
      if (edges_since_rst != 20) begin
         errors++;
         $display("FAIL rd_align got %0d want 20", edges_since_rst);
      end
      drive_rd(A_STATUS);
      step();
      exp_cyc = edges_since_rst;
      drive_rd(A_CYCLE);
      checks++;
      if (rd_resp_valid !== 1'b1 || rd_data !== 32'h2) begin
         errors++;
         $display("FAIL rd_status got v=%b d=%0h want v=1 d=2", rd_resp_valid, rd_data);
      end
      step();
      drive_rd(BASE + 32'h40);
      checks++;
      if (rd_resp_valid !== 1'b1 || rd_data !== exp_cyc) begin
         errors++;
         $display("FAIL rd_cycle got v=%b d=%0h want v=1 d=%0h", rd_resp_valid, rd_data, exp_cyc);
      end
      step();
      drive_rd(A_TOHOST);
      checks++;
      if (rd_resp_valid !== 1'b1 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL rd_unmapped got v=%b d=%0h want v=1 d=0", rd_resp_valid, rd_data);
      end
      step();
      drive_rd(A_CONSOLE);
      checks++;
      if (rd_resp_valid !== 1'b1 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL rd_tohost got v=%b d=%0h want v=1 d=0", rd_resp_valid, rd_data);
      end
      step();
      idle_bus();
      checks++;
      if (rd_resp_valid !== 1'b1 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL rd_console got v=%b d=%0h want v=1 d=0", rd_resp_valid, rd_data);
      end
      step();
      checks++;
      if (rd_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_idle got %b want 0", rd_resp_valid);
      end
   endtask

   task automatic test_reset_drain();
      do_reset();
      con_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_wr(A_CONSOLE, 32'h30 + i);
         step();
      end
      idle_bus();
      drive_rd(A_CYCLE);
      drive_wr(A_TOHOST, 32'h0000_0015);
      step();
      idle_bus();
      step();
      checks++;
      if (con_valid !== 1'b1 || halt !== 1'b0 || rd_data === 32'h0) begin
         errors++;
         $display("FAIL rst_drain_pre got cv=%b h=%b rd=%0h want cv=1 h=0 rd!=0", con_valid, halt, rd_data);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({con_valid, halt, pass, rd_resp_valid} !== 4'b0000 || exit_code !== 31'd0 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL rst_drain_async got cv=%b h=%b p=%b rv=%b e=%0h rd=%0h want all 0",
                  con_valid, halt, pass, rd_resp_valid, exit_code, rd_data);
      end
      @(negedge clock);
      reset = 1'b0;
      con_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (con_valid !== 1'b0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain_after c=%0d got cv=%b h=%b want 0 0", c, con_valid, halt);
         end
      end
      con_ready = 1'b0;
   endtask

`ifdef TEST_HOST_WATCHDOG_EN
   task automatic test_watchdog();
      int unsigned seen;
      do_reset();
      seen = 0;
      for (int c = 0; c < 200 && seen == 0; c++) begin
         step();
         if (halt === 1'b1) seen = edges_since_rst;
      end
      checks++;
      if (seen != 51) begin
         errors++;
         $display("FAIL wd_halt_cycle got %0d want 51", seen);
      end
      checks++;
      if (pass !== 1'b0 || exit_code !== 31'h7FFF_FFFF) begin
         errors++;
         $display("FAIL wd_verdict got p=%b e=%0h want p=0 e=7fffffff", pass, exit_code);
      end
   endtask
`endif

   // ------------------------------------------------------------
   // Sequence and report
   // ------------------------------------------------------------
   initial begin
      test_reset();
`ifdef TEST_HOST_WATCHDOG_EN
      test_watchdog();
`else
      test_tohost();
      test_console_hi();
      test_backpressure();
      test_random();
      test_reads();
      test_reset_drain();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
